// File: rtl/i2c_slave_regfile_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C slave register file:
//   REG_W       - register / data byte width
//   rx_state_e  - receive state: next written byte is the pointer or data
//   ptr_w(n)    - register pointer width for an n-entry register file
// ---------------------------------------------------------------------------
package i2c_pkg;

  localparam int REG_W = 8;

  // ST_PTR: the next received byte loads the register pointer.
  // ST_DATA: received bytes are stored at the pointer with auto-increment.
  typedef enum logic {
    ST_DATA = 1'b0,
    ST_PTR  = 1'b1
  } rx_state_e;

  function automatic int ptr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/i2c_slave_regfile_edge_det.sv
// ---------------------------------------------------------------------------
// edge_det
// One-bit edge detector. The input is registered once; a rising or falling
// edge produces a registered one-cycle pulse in the cycle after the edge is
// first sampled.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   d    - level input (synchronous to clk)
//   rise - one-cycle pulse after a 0->1 transition of d
//   fall - one-cycle pulse after a 1->0 transition of d
// ---------------------------------------------------------------------------
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_r;

  // Delay the input and register the edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_r  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      d_r  <= d;
      rise <= d & ~d_r;
      fall <= ~d & d_r;
    end
  end

endmodule

// File: rtl/i2c_slave_regfile.sv
// ---------------------------------------------------------------------------
// i2c_slave_regfile
// EEPROM-style register file behind an I2C slave. The first byte written in
// a transaction sets the register pointer; further written bytes are stored
// with auto-increment. Read transactions stream registers from the pointer.
// A host port gives parallel single-cycle register access.
// Parameters:
//   NREGS   - number of 8-bit registers (power of two, 2..256)
//   RO_MASK - bit i set makes register i read-only from I2C
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   s_busy, s_rnw            - slave transaction active, R/W bit
//   s_new_data, s_rx_data    - received-byte level and byte
//   s_data_req, s_tx_data    - transmit request level and byte to send
//   host_we/addr/wdata/rdata - host register port (rdata registered)
//   i2c_wr, i2c_wr_addr      - pulse and address of each I2C register write
//   ptr                      - current register pointer (debug)
// ---------------------------------------------------------------------------
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter int               NREGS   = 16,
  parameter logic [NREGS-1:0] RO_MASK = {NREGS{1'b0}}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_busy,
  input  logic                      s_rnw,
  input  logic                      s_new_data,
  input  logic [REG_W-1:0]          s_rx_data,
  input  logic                      s_data_req,
  output logic [REG_W-1:0]          s_tx_data,
  input  logic                      host_we,
  input  logic [ptr_w(NREGS)-1:0]   host_addr,
  input  logic [REG_W-1:0]          host_wdata,
  output logic [REG_W-1:0]          host_rdata,
  output logic                      i2c_wr,
  output logic [ptr_w(NREGS)-1:0]   i2c_wr_addr,
  output logic [ptr_w(NREGS)-1:0]   ptr
);

  localparam int PW = ptr_w(NREGS);

  logic [REG_W-1:0] mem_r [NREGS];
  rx_state_e        state_r;

  logic          nd_ev_s;
  logic          rq_ev_s;
  logic          bs_rise_s;
  logic          bs_fall_s;
  logic          nd_fall_unused_s;
  logic          rq_fall_unused_s;
  logic          nd_ptr_s;
  logic          nd_data_s;
  logic          i2c_we_s;
  logic          rd_s;
  logic [PW-1:0] ptr_inc_s;

  edge_det u_nd_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (s_new_data),
    .rise (nd_ev_s),
    .fall (nd_fall_unused_s)
  );

  edge_det u_rq_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (s_data_req),
    .rise (rq_ev_s),
    .fall (rq_fall_unused_s)
  );

  // A falling busy edge (STOP or abort) re-arms the pointer byte just like START.
  edge_det u_bs_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (s_busy),
    .rise (bs_rise_s),
    .fall (bs_fall_s)
  );

  // Decode slave events into pointer load, data write and read fetch.
  always_comb begin
    nd_ptr_s  = 1'b0;
    nd_data_s = 1'b0;
    i2c_we_s  = 1'b0;
    rd_s      = 1'b0;
    ptr_inc_s = ptr + PW'(1);
    if (nd_ev_s) begin
      if (state_r == ST_PTR) begin
        nd_ptr_s = 1'b1;
      end else begin
        nd_data_s = 1'b1;
        i2c_we_s  = ~RO_MASK[ptr];
      end
    end else begin
      // A request colliding with a received byte is dropped; a request
      // during a write transaction is the address ack and is ignored.
      rd_s = rq_ev_s & s_rnw;
    end
  end

  // Receive state, pointer, transmit byte and I2C write pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_PTR;
      ptr         <= {PW{1'b0}};
      s_tx_data   <= {REG_W{1'b0}};
      i2c_wr      <= 1'b0;
      i2c_wr_addr <= {PW{1'b0}};
    end else begin
      i2c_wr <= i2c_we_s;
      if (i2c_we_s) begin
        i2c_wr_addr <= ptr;
      end

      case (state_r)
        ST_PTR: begin
          if (nd_ptr_s) begin
            ptr     <= s_rx_data[PW-1:0];
            state_r <= ST_DATA;
          end else if (rd_s) begin
            s_tx_data <= mem_r[ptr];
            ptr       <= ptr_inc_s;
            state_r   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (nd_data_s) begin
            ptr <= ptr_inc_s;
          end else if (rd_s) begin
            s_tx_data <= mem_r[ptr];
            ptr       <= ptr_inc_s;
          end
        end
        default: begin
          state_r <= ST_PTR;
        end
      endcase

      // Transaction boundaries override: the next byte is a pointer byte.
      if (bs_rise_s || bs_fall_s) begin
        state_r <= ST_PTR;
      end
    end
  end

  // Register array and host read port; the host write is ordered last so it
  // wins a same-cycle collision with an I2C write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_r[i] <= {REG_W{1'b0}};
      end
      host_rdata <= {REG_W{1'b0}};
    end else begin
      host_rdata <= mem_r[host_addr];
      if (i2c_we_s) begin
        mem_r[ptr] <= s_rx_data;
      end
      if (host_we) begin
        mem_r[host_addr] <= host_wdata;
      end
    end
  end

endmodule
